// File: rtl/apb_master_pkg.sv
// Shared constants for the APB command master: FSM state encoding and default timeout.
package apb_master_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam int DEFAULT_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/apb_cmd_master.sv
// Single-outstanding APB master: turns one command into one APB transfer and returns
// one response, with an optional wait-state timeout.
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// SETUP  | PSEL=1, PENABLE=0 for one cycle
// ACCESS | PSEL=1, PENABLE=1 until PREADY or timeout
// RESP   | rsp_valid high, holding the response until rsp_ready
module apb_cmd_master
    import apb_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [9:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [9:0]  PADDR,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int LAST  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT_CYCLES);

    logic [1:0]       state;
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_hit;

    assign cmd_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign PSEL      = (state == ST_SETUP) || (state == ST_ACCESS);
    assign PENABLE   = (state == ST_ACCESS);

    // This cycle's PREADY=0 would bring the count to TIMEOUT_CYCLES.
    assign timeout_hit = (TIMEOUT_CYCLES > 0) && (wait_cnt == CNT_LAST);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        PWRITE <= cmd_write;
                        PADDR  <= cmd_addr;
                        PWDATA <= cmd_wdata;
                        state  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    wait_cnt <= '0;
                    state    <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (PREADY) begin
                        // Read data is only meaningful for a successful read.
                        rsp_rdata   <= (PWRITE || PSLVERR) ? 32'd0 : PRDATA;
                        rsp_err     <= PSLVERR;
                        rsp_timeout <= 1'b0;
                        state       <= ST_RESP;
                    end else begin
                        if (wait_cnt != CNT_SAT) begin
                            wait_cnt <= wait_cnt + CNT_W'(1);
                        end
                        if (timeout_hit) begin
                            rsp_rdata   <= '0;
                            rsp_err     <= 1'b1;
                            rsp_timeout <= 1'b1;
                            state       <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master (TIMEOUT_CYCLES=4) with a response scoreboard.
module tb_apb_cmd_master;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } rsp_t;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [9:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err, rsp_timeout;
    logic        PSEL, PENABLE, PWRITE;
    logic [9:0]  PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic        PREADY, PSLVERR;

    int   checks = 0;
    int   errors = 0;
    rsp_t sb[$];

    apb_cmd_master #(.TIMEOUT_CYCLES(4)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // One transfer: ready_after = PREADY-low cycles before PREADY=1 (>=4 means timeout).
    task automatic xfer(input logic wr, input logic [9:0] addr, input logic [31:0] wdata,
                        input int ready_after, input logic [31:0] prdata,
                        input logic slverr, input int hold);
        rsp_t exp;
        bit   to;
        int   n;
        to = (ready_after >= 4);
        exp.to    = to;
        exp.err   = to ? 1'b1 : slverr;
        exp.rdata = (wr || to || slverr) ? 32'd0 : prdata;

        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
        chk("cmd_ready_idle", cmd_ready, 1'b1);
        sb.push_back(exp);
        tick();
        cmd_valid = 1'b0; cmd_addr = ~addr; cmd_wdata = ~wdata; cmd_write = ~wr;
        chk("setup_psel", PSEL, 1'b1);
        chk("setup_penable", PENABLE, 1'b0);
        chk("setup_paddr", PADDR, addr);
        chk("setup_pwrite", PWRITE, wr);
        chk("setup_pwdata", PWDATA, wdata);
        tick();
        n = 0;
        while (PSEL === 1'b1 && PENABLE === 1'b1 && n < 40) begin
            n++;
            PREADY  = (n == ready_after + 1);
            PRDATA  = PREADY ? prdata : 32'hBAD0_BAD0;
            PSLVERR = PREADY ? slverr : 1'b1;
            if (PADDR !== addr || PWDATA !== wdata || PWRITE !== wr)
                chk("access_stable", {PWRITE, PADDR}, {wr, addr});
            tick();
        end
        PREADY = 1'b0; PSLVERR = 1'b1; PRDATA = 32'hFFFF_FFFF;
        chk("access_cycles", n, to ? 4 : ready_after + 1);
        chk("resp_psel", PSEL, 1'b0);
        chk("resp_penable", PENABLE, 1'b0);
        chk("resp_valid", rsp_valid, 1'b1);
        if (sb.size() == 0) begin
            chk("sb_nonempty", 0, 1);
        end else begin
            for (int i = 0; i < hold; i++) begin
                cmd_valid = 1'b1; cmd_addr = 10'h111;
                chk("hold_rsp", {rsp_rdata, rsp_err, rsp_timeout, rsp_valid},
                    {sb[0].rdata, sb[0].err, sb[0].to, 1'b1});
                chk("hold_cmd_ready", cmd_ready, 1'b0);
                chk("hold_psel", PSEL, 1'b0);
                tick();
            end
            exp = sb.pop_front();
            chk("rsp_rdata", rsp_rdata, exp.rdata);
            chk("rsp_err", rsp_err, exp.err);
            chk("rsp_timeout", rsp_timeout, exp.to);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        PSLVERR = 1'b0; PRDATA = '0;
        chk("back_idle_ready", cmd_ready, 1'b1);
        chk("back_idle_valid", rsp_valid, 1'b0);
        tick();
        chk("no_queued_cmd", PSEL, 1'b0);
    endtask

    initial begin
        PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        repeat (2) @(posedge PCLK);
        #1;
        chk("rst_outputs", {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout}, 6'b0);
        chk("rst_paddr", PADDR, 10'h0);
        chk("rst_pwdata", PWDATA, 32'h0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        PRESETn = 1'b1;
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        tick();

        xfer(1'b1, 10'h300, 32'h1ACC_E551, 0, 32'h0, 1'b0, 0);
        xfer(1'b0, 10'h3F8, 32'h0,         0, 32'h0000_000D, 1'b0, 0);
        xfer(1'b0, 10'h055, 32'h0,         3, 32'hCAFE_0001, 1'b1, 1);
        xfer(1'b0, 10'h0A5, 32'h0,         99, 32'h1234_5678, 1'b0, 5);
        xfer(1'b1, 10'h2C3, $urandom,      2, 32'h0, 1'b0, 2);
        xfer(1'b0, 10'h001, 32'h0,         1, 32'h8000_0001, 1'b0, 0);

        // Reset in the middle of a stalled access: transfer is dropped.
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 10'h2AA; cmd_wdata = 32'h5555_AAAA;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("pre_rst_access", PENABLE, 1'b1);
        tick();
        #2;
        PRESETn = 1'b0;
        #1;
        chk("async_rst_ctrl", {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout}, 6'b0);
        chk("async_rst_paddr", PADDR, 10'h0);
        chk("async_rst_pwdata", PWDATA, 32'h0);
        @(posedge PCLK);
        #1;
        PRESETn = 1'b1;
        chk("post_rst_ready", cmd_ready, 1'b1);
        repeat (3) begin
            tick();
            chk("post_rst_no_rsp", {rsp_valid, PSEL}, 2'b00);
        end

        xfer(1'b0, 10'h3FF, 32'h0, 0, 32'hA5A5_5A5A, 1'b0, 0);
        chk("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_cmd_master.md
APB_CMD_MASTER -- requirements
Module: apb_cmd_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: max consecutive ACCESS cycles with PREADY low; 0 disables the timeout.
REQ-002 PCLK  in  1  single clock for all logic.
REQ-003 PRESETn  in  1  reset, asynchronous, active-low.
REQ-004 cmd_valid  in  1  command request.
REQ-005 cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-006 cmd_write  in  1  1 = write, 0 = read.
REQ-007 cmd_addr  in  10  word address, driven on PADDR[11:2].
REQ-008 cmd_wdata  in  32  write data.
REQ-009 rsp_valid  out  1  response available.
REQ-010 rsp_ready  in  1  response consumed when high with rsp_valid.
REQ-011 rsp_rdata  out  32  read data; 0 for writes, errors and timeouts.
REQ-012 rsp_err  out  1  PSLVERR sampled at completion, or timeout.
REQ-013 rsp_timeout  out  1  transfer aborted by timeout.
REQ-014 PSEL, PENABLE, PWRITE  out  1 each  APB control.
REQ-015 PADDR  out  10  APB address [11:2].
REQ-016 PWDATA  out  32  APB write data.
REQ-017 PRDATA  in  32; PREADY  in  1 (tie high for zero-wait slaves); PSLVERR  in  1.

Function
REQ-018 FSM states SHALL be IDLE, SETUP, ACCESS, RESP; one transfer in flight.
REQ-019 cmd_ready SHALL be 1 only in IDLE; a handshake in IDLE registers cmd_write/addr/wdata into PWRITE/PADDR/PWDATA and moves to SETUP.
REQ-020 SETUP SHALL drive PSEL=1, PENABLE=0 for exactly one cycle, then move to ACCESS.
REQ-021 ACCESS SHALL drive PSEL=1, PENABLE=1 until PREADY=1 or timeout.
REQ-022 PADDR, PWRITE, PWDATA SHALL stay constant from SETUP through ACCESS and retain their values in IDLE/RESP.
REQ-023 With PREADY=1 in ACCESS, the block SHALL capture PRDATA (reads only) and PSLVERR into rsp_rdata/rsp_err, set rsp_timeout=0, and enter RESP.
REQ-024 The wait counter SHALL clear on entering ACCESS and increment each ACCESS cycle with PREADY=0.
REQ-025 If TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES with PREADY still 0, the block SHALL enter RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-026 PREADY=1 in the cycle the count reaches TIMEOUT_CYCLES SHALL count as normal completion.
REQ-027 Counter width SHALL be clog2(TIMEOUT_CYCLES+1) and SHALL saturate without wrap.
REQ-028 On entering RESP, PSEL and PENABLE SHALL drop to 0 in the same cycle.
REQ-029 rsp_valid SHALL be 1 only in RESP; response fields hold stable until rsp_ready=1, then the FSM returns to IDLE.
REQ-030 Zero-wait latency: handshake at cycle N -> SETUP at N+1, ACCESS at N+2, rsp_valid at N+3; earliest next cmd_ready is at N+4 if rsp_ready=1 at N+3.
REQ-031 cmd_valid in non-IDLE states SHALL be ignored and not queued.
REQ-032 PSLVERR and PRDATA SHALL be ignored outside ACCESS and in ACCESS cycles with PREADY=0.

Reset
REQ-033 PRESETn low SHALL immediately force IDLE and clear PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, and the wait counter.
REQ-034 A transfer in flight at reset SHALL be dropped with no response generated.
REQ-035 cmd_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-036 Package apb_master_pkg SHALL hold the FSM state encoding and the default TIMEOUT_CYCLES constant.
REQ-037 The block SHALL be a single module; the wait counter stays inline and has no sub-module.

Verification
REQ-038 Write 0x1ACCE551 to addr 0x300, PREADY=1 -> SETUP/ACCESS one cycle each, PADDR=0x300, PWRITE=1, rsp_valid at N+3, rsp_err=0.
REQ-039 Read addr 0x3F8, PRDATA=0x0D, PREADY=1 -> rsp_rdata=0x0000000D, rsp_err=0.
REQ-040 Read with PREADY low for 3 cycles then high, PSLVERR=1 -> ACCESS lasts 4 cycles, rsp_err=1, rsp_timeout=0.
REQ-041 TIMEOUT_CYCLES=4, PREADY held 0 -> abort after 4 ACCESS cycles, PSEL=0, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-042 rsp_ready held 0 for 5 cycles while cmd_valid=1 -> response stable, cmd_ready=0, no new SETUP.
REQ-043 PRESETn asserted mid-ACCESS -> all outputs 0 asynchronously, no rsp_valid, cmd_ready=1 after release.
